multi_pulser: RTL and testbench

- Parametrised, multi-channel successor to the single-input one-pulser.
- Each channel does the following:
  - synchronises a raw button/switch level;
  - debounces it;
  - emits single-cycle pulses on a selectable edge;
  - optionally auto-repeats while the input is held.
- Sits between board push-buttons and downstream FSMs or counters that need exactly one event per press.

---
 rtl/multi_pulser_pkg.sv | 21 ++
 rtl/pulser_channel.sv | 152 +++++++++++++++
 rtl/multi_pulser.sv | 51 +++++
 tb/tb_multi_pulser.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_pulser_pkg.sv
// Shared constants for the multi-channel pulser: edge-select modes,
// repeat-FSM state encodings and a small elaboration-time helper.
package multi_pulser_pkg;

  // Edge-select encodings for the shared mode input
  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // Auto-repeat FSM states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_REP  = 2'd2;

  // Larger of two integers, used to size the repeat counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulser_channel.sv
// One pulser channel: 2-flop synchroniser, debounce counter, edge
// detection against the shared mode, and an optional auto-repeat FSM.
// o_sp_nxt is the value o_sp takes at the next edge, so the top level
// can register an OR of all channels in step with o_sp.
module pulser_channel
  import multi_pulser_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_lp,
  input  logic [1:0] i_mode,
  output logic       o_sp_nxt,
  output logic       o_sp,
  output logic       o_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_sp;
  logic          w_diff;
  logic          w_flip;
  logic          w_rise;
  logic          w_fall;
  logic          w_edge_pulse;
  logic          w_rep_pulse;
  logic          w_sp_nxt;

  // Two-flop synchroniser for the asynchronous level input
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_lp;
      r_s2 <= r_s1;
    end
  end

  // The level flips on the edge where the disagreement has lasted long enough
  assign w_diff = r_s2 ^ r_level;
  assign w_flip = w_diff && (r_cnt == CNT_LAST);
  assign w_rise = w_flip && r_s2;
  assign w_fall = w_flip && !r_s2;

  // Debounce: count consecutive disagreeing cycles, any agreement restarts
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (w_flip) begin
      r_level <= r_s2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Edge pulse for a level change that matches the selected mode
  assign w_edge_pulse = (w_rise && ((i_mode == MODE_RISE) || (i_mode == MODE_BOTH)))
                     || (w_fall && ((i_mode == MODE_FALL) || (i_mode == MODE_BOTH)));

  if (REPEAT_DELAY > 0) begin : g_rep
    logic [1:0]    r_state;
    logic [RW-1:0] r_rcnt;
    logic          w_rep_ok;
    logic          w_rep_due;

    assign w_rep_ok = (i_mode == MODE_RISE) || (i_mode == MODE_BOTH);

    // Repeat is due when the counter reaches the compare value of the state
    always_comb begin
      w_rep_due = 1'b0;
      case (r_state)
        R_WAIT:  w_rep_due = (r_rcnt == RW'(REPEAT_DELAY));
        R_REP:   w_rep_due = (r_rcnt == RW'(REPEAT_PERIOD));
        default: w_rep_due = 1'b0;
      endcase
    end

    // A falling level wins over a due repeat; that repeat is dropped
    assign w_rep_pulse = w_rep_due && w_rep_ok && !w_fall;

    // Repeat FSM: armed by a rising press pulse, cancelled by release or mode off
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_state <= R_IDLE;
        r_rcnt  <= '0;
      end else if ((i_mode == MODE_OFF) || w_fall) begin
        r_state <= R_IDLE;
        r_rcnt  <= '0;
      end else begin
        case (r_state)
          R_IDLE: begin
            if (w_rise && w_rep_ok) begin
              r_state <= R_WAIT;
              r_rcnt  <= RW'(1);
            end
          end
          R_WAIT: begin
            if (w_rep_due) begin
              r_state <= R_REP;
              r_rcnt  <= RW'(1);
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
          R_REP: begin
            if (w_rep_due) begin
              r_rcnt <= RW'(1);
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
          default: begin
            r_state <= R_IDLE;
            r_rcnt  <= '0;
          end
        endcase
      end
    end
  end else begin : g_norep
    assign w_rep_pulse = 1'b0;
  end

  assign w_sp_nxt = w_edge_pulse || w_rep_pulse;

  // Registered single-cycle output pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sp <= 1'b0;
    end else begin
      r_sp <= w_sp_nxt;
    end
  end

  assign o_sp_nxt = w_sp_nxt;
  assign o_sp     = r_sp;
  assign o_level  = r_level;

endmodule

// File: rtl/multi_pulser.sv
// Multi-channel debounced one-pulser with optional auto-repeat.
// Replicates pulser_channel per input and registers an OR of the
// next-cycle pulses so sp_any lines up with sp.
module multi_pulser
  import multi_pulser_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] lp,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] sp,
  output logic [CHANNELS-1:0] level,
  output logic                sp_any
);

  logic [CHANNELS-1:0] w_sp_nxt;
  logic                r_sp_any;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulser_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_lp     (lp[i]),
      .i_mode   (mode),
      .o_sp_nxt (w_sp_nxt[i]),
      .o_sp     (sp[i]),
      .o_level  (level[i])
    );
  end

  // Any-channel pulse, registered on the same edge as the per-channel pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp_any <= 1'b0;
    end else begin
      r_sp_any <= |w_sp_nxt;
    end
  end

  assign sp_any = r_sp_any;

endmodule

// File: tb/tb_multi_pulser.sv
// Directed bench for multi_pulser. dut0 has auto-repeat off, dut1 has
// REPEAT_DELAY=8 / REPEAT_PERIOD=4; both use DEBOUNCE_CYCLES=4.
// Edge numbering: the first posedge after a test's stimulus is set is
// edge 0; outputs are sampled 1 time unit after each edge and inputs are
// changed right after sampling.
module tb_multi_pulser;
  import multi_pulser_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] lp0, lp1;
  logic [1:0] mode0, mode1;
  logic [3:0] sp0, sp1, level0, level1;
  logic       any0, any1;

  int n_checks;
  int n_fail;
  logic [7:0] exp_q[$];

  multi_pulser #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(4)) dut0 (
    .clk(clk), .rst(rst), .lp(lp0), .mode(mode0), .sp(sp0), .level(level0), .sp_any(any0)
  );

  multi_pulser #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut1 (
    .clk(clk), .rst(rst), .lp(lp1), .mode(mode1), .sp(sp1), .level(level1), .sp_any(any1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    lp0 = '0; lp1 = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({sp0, level0, any0} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_dut0 got sp=%b level=%b any=%b want all 0", sp0, level0, any0);
    end
    n_checks++;
    if ({sp1, level1, any1} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_dut1 got sp=%b level=%b any=%b want all 0", sp1, level1, any1);
    end
  endtask

  // Press channel 0 for edges 0..19 in rising mode: one pulse at 5, level 5..24
  task automatic test_basic();
    logic [3:0] exp_sp;
    logic [3:0] exp_lv;
    do_reset();
    mode0 = MODE_RISE; lp0 = 4'b0001;
    exp_q = {8'd5};
    for (int e = 0; e <= 30; e++) begin
      @(posedge clk); #1;
      exp_sp = 4'b0;
      if (exp_q.size() != 0 && exp_q[0] == 8'(e)) begin
        exp_sp = 4'b0001;
        void'(exp_q.pop_front());
      end
      exp_lv = (e >= 5 && e < 25) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (sp0 !== exp_sp) begin n_fail++; $display("FAIL basic_sp e=%0d got %b want %b", e, sp0, exp_sp); end
      n_checks++;
      if (any0 !== (exp_sp != 0)) begin n_fail++; $display("FAIL basic_any e=%0d got %b want %b", e, any0, exp_sp != 0); end
      n_checks++;
      if (level0 !== exp_lv) begin n_fail++; $display("FAIL basic_level e=%0d got %b want %b", e, level0, exp_lv); end
      if (e == 19) lp0 = 4'b0;
    end
  endtask

  // Channel 1 high for 3 samples is rejected; high for 4 samples is accepted
  task automatic test_glitch();
    logic [3:0] exp_sp;
    logic [3:0] exp_lv;
    do_reset();
    mode0 = MODE_RISE; lp0 = 4'b0010;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sp0 !== 4'b0 || level0 !== 4'b0) begin
        n_fail++; $display("FAIL glitch_reject e=%0d got sp=%b level=%b want 0", e, sp0, level0);
      end
      if (e == 2) lp0 = 4'b0;
    end
    do_reset();
    lp0 = 4'b0010;
    for (int e = 0; e <= 12; e++) begin
      @(posedge clk); #1;
      exp_sp = (e == 5) ? 4'b0010 : 4'b0000;
      exp_lv = (e >= 5 && e < 9) ? 4'b0010 : 4'b0000;
      n_checks++;
      if (sp0 !== exp_sp || level0 !== exp_lv) begin
        n_fail++; $display("FAIL glitch_min e=%0d got sp=%b level=%b want sp=%b level=%b", e, sp0, level0, exp_sp, exp_lv);
      end
      if (e == 3) lp0 = 4'b0;
    end
  endtask

  // Falling-only and both-edge modes on channels 2 and 3, held edges 0..9
  task automatic test_edges(input logic [1:0] m, input logic [3:0] ch);
    logic [3:0] exp_sp;
    logic [3:0] exp_lv;
    do_reset();
    mode0 = m; lp0 = ch;
    exp_q.delete();
    if (m == MODE_BOTH) exp_q.push_back(8'd5);
    exp_q.push_back(8'd15);
    for (int e = 0; e <= 20; e++) begin
      @(posedge clk); #1;
      exp_sp = 4'b0;
      if (exp_q.size() != 0 && exp_q[0] == 8'(e)) begin
        exp_sp = ch;
        void'(exp_q.pop_front());
      end
      exp_lv = (e >= 5 && e < 15) ? ch : 4'b0000;
      n_checks++;
      if (sp0 !== exp_sp || any0 !== (exp_sp != 0)) begin
        n_fail++; $display("FAIL edges_m%0d_sp e=%0d got sp=%b any=%b want %b", m, e, sp0, any0, exp_sp);
      end
      n_checks++;
      if (level0 !== exp_lv) begin n_fail++; $display("FAIL edges_m%0d_level e=%0d got %b want %b", m, e, level0, exp_lv); end
      if (e == 9) lp0 = 4'b0;
    end
  endtask

  // Auto-repeat on channel 2 held edges 0..29
  task automatic test_repeat();
    logic [3:0] exp_sp;
    logic [3:0] exp_lv;
    do_reset();
    mode1 = MODE_RISE; lp1 = 4'b0100;
    exp_q = {8'd5, 8'd13, 8'd17, 8'd21, 8'd25, 8'd29, 8'd33};
    for (int e = 0; e <= 42; e++) begin
      @(posedge clk); #1;
      exp_sp = 4'b0;
      if (exp_q.size() != 0 && exp_q[0] == 8'(e)) begin
        exp_sp = 4'b0100;
        void'(exp_q.pop_front());
      end
      exp_lv = (e >= 5 && e < 35) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (sp1 !== exp_sp || any1 !== (exp_sp != 0)) begin
        n_fail++; $display("FAIL repeat_sp e=%0d got sp=%b any=%b want %b", e, sp1, any1, exp_sp);
      end
      n_checks++;
      if (level1 !== exp_lv) begin n_fail++; $display("FAIL repeat_level e=%0d got %b want %b", e, level1, exp_lv); end
      if (e == 29) lp1 = 4'b0;
    end
  endtask

  // Release lands on the same edge (17) as a due repeat
  task automatic test_fall_vs_repeat(input logic [1:0] m);
    logic [3:0] exp_sp;
    do_reset();
    mode1 = m; lp1 = 4'b0010;
    exp_q = {8'd5, 8'd13};
    if (m == MODE_BOTH) exp_q.push_back(8'd17);
    for (int e = 0; e <= 26; e++) begin
      @(posedge clk); #1;
      exp_sp = 4'b0;
      if (exp_q.size() != 0 && exp_q[0] == 8'(e)) begin
        exp_sp = 4'b0010;
        void'(exp_q.pop_front());
      end
      n_checks++;
      if (sp1 !== exp_sp) begin n_fail++; $display("FAIL fall_rep_m%0d e=%0d got %b want %b", m, e, sp1, exp_sp); end
      if (e == 11) lp1 = 4'b0;
    end
  endtask

  // Mode off from edge 10 to 19 during a held press, then a release and new press
  task automatic test_disable();
    logic [3:0] exp_sp;
    logic [3:0] exp_lv;
    do_reset();
    mode1 = MODE_RISE; lp1 = 4'b0001;
    exp_q = {8'd5, 8'd46, 8'd54};
    for (int e = 0; e <= 56; e++) begin
      @(posedge clk); #1;
      exp_sp = 4'b0;
      if (exp_q.size() != 0 && exp_q[0] == 8'(e)) begin
        exp_sp = 4'b0001;
        void'(exp_q.pop_front());
      end
      exp_lv = ((e >= 5 && e < 36) || e >= 46) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (sp1 !== exp_sp || any1 !== (exp_sp != 0)) begin
        n_fail++; $display("FAIL disable_sp e=%0d got sp=%b any=%b want %b", e, sp1, any1, exp_sp);
      end
      n_checks++;
      if (level1 !== exp_lv) begin n_fail++; $display("FAIL disable_level e=%0d got %b want %b", e, level1, exp_lv); end
      if (e == 9)  mode1 = MODE_OFF;
      if (e == 19) mode1 = MODE_RISE;
      if (e == 30) lp1 = 4'b0;
      if (e == 40) lp1 = 4'b0001;
    end
  endtask

  // Reset sampled at edge 15 while channel 0 is held and repeating
  task automatic test_reset_mid();
    logic [3:0] exp_sp;
    logic [3:0] exp_lv;
    do_reset();
    mode1 = MODE_RISE; lp1 = 4'b0001;
    exp_q = {8'd5, 8'd13, 8'd21, 8'd29};
    for (int e = 0; e <= 31; e++) begin
      @(posedge clk); #1;
      exp_sp = 4'b0;
      if (exp_q.size() != 0 && exp_q[0] == 8'(e)) begin
        exp_sp = 4'b0001;
        void'(exp_q.pop_front());
      end
      exp_lv = ((e >= 5 && e < 15) || e >= 21) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (sp1 !== exp_sp || any1 !== (exp_sp != 0)) begin
        n_fail++; $display("FAIL rstmid_sp e=%0d got sp=%b any=%b want %b", e, sp1, any1, exp_sp);
      end
      n_checks++;
      if (level1 !== exp_lv) begin n_fail++; $display("FAIL rstmid_level e=%0d got %b want %b", e, level1, exp_lv); end
      if (e == 14) rst = 1'b1;
      if (e == 15) rst = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    lp0   = '0;
    lp1   = '0;
    mode0 = MODE_RISE;
    mode1 = MODE_RISE;
    test_reset();
    test_basic();
    test_glitch();
    test_edges(MODE_FALL, 4'b0100);
    test_edges(MODE_BOTH, 4'b1000);
    test_repeat();
    test_fall_vs_repeat(MODE_RISE);
    test_fall_vs_repeat(MODE_BOTH);
    test_disable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
